// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier, 32x32 signed to 64-bit hi/lo
// One Booth step per clock; results are registered and held until the next product completes.
module booth_mult_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [32:0] m_q, m_d;
  logic [32:0] a_q, a_d;
  logic [31:0] q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        ovf_q, ovf_d;

  logic [32:0] a_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ovf_d   = ovf_q;
    a_step  = a_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = {multiplicand[31], multiplicand};
          a_d     = '0;
          q_d     = multiplier;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == 6'd32) begin
          // All 32 steps are in; publish the product {A[31:0], Q} in one registered update.
          hi_d    = a_q[31:0];
          lo_d    = q_q;
          ovf_d   = (a_q[31:0] != {32{q_q[31]}});
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          case ({q_q[0], qm1_q})
            2'b01:   a_step = a_q + m_q;
            2'b10:   a_step = a_q - m_q;
            default: a_step = a_q;
          endcase
          // Arithmetic right shift of {A, Q, Q-1} with A's sign bit replicated.
          a_d   = {a_step[32], a_step[32:1]};
          q_d   = {a_step[0], q_q[31:1]};
          qm1_d = q_q[0];
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign overflow = ovf_q;

endmodule
